// File: rtl/counter_ctrl.sv
// Run/pause/clear controller for a 14-bit counter: synchronizes and debounces a switch and a
// button, sequences IDLE/RUN/PAUSE/CLEAR and emits prescaled increment and clear strobes.
module counter_ctrl #(
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_signal,
    input  logic       rst_signal,
    input  logic       switch_raw,
    input  logic       button_raw,
    output logic       count_en,
    output logic       count_clr,
    output logic       switch_db,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StClear = 2'd3
    } state_e;

    // Bit 0 carries the switch, bit 1 the button.
    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         stable_q, stable_d;
    logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic               btn_prev_q;
    logic               btn_rise;
    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;

    assign raw = {button_raw, switch_raw};

    always_ff @(posedge clk_signal or posedge rst_signal) begin
        if (rst_signal) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            db_cnt_q   <= '0;
            btn_prev_q <= 1'b0;
            state_q    <= StIdle;
            presc_q    <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            btn_prev_q <= stable_q[1];
            state_q    <= state_d;
            presc_q    <= presc_d;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
        end
    end

    assign btn_rise = stable_q[1] & ~btn_prev_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (btn_rise) state_d = StClear;
                else if (stable_q[0]) state_d = StRun;
            end
            StRun: begin
                if (btn_rise) state_d = StClear;
                else if (!stable_q[0]) state_d = StPause;
            end
            StPause: begin
                if (btn_rise) state_d = StClear;
                else if (stable_q[0]) state_d = StRun;
            end
            StClear: begin
                state_d = stable_q[0] ? StRun : StIdle;
            end
        endcase
    end

    // Held in PAUSE so the tick phase survives a pause/resume.
    always_comb begin
        presc_d = '0;
        unique case (state_q)
            StRun:   presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
            StPause: presc_d = presc_q;
            default: presc_d = '0;
        endcase
    end

    assign count_en  = (state_q == StRun) && (presc_q == PRESC_MAX);
    assign count_clr = (state_q == StClear);
    assign switch_db = stable_q[0];
    assign state     = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3; expectations are
// hand-derived cycle counts relative to input changes.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw  = 1'b0;
    logic       btn = 1'b0;
    logic       count_en;
    logic       count_clr;
    logic       switch_db;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int c        = 0;  // RUN-cycle index since the last prescaler restart

    counter_ctrl #(
        .TICK_DIV       (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk_signal(clk),
        .rst_signal(rst),
        .switch_raw(sw),
        .button_raw(btn),
        .count_en  (count_en),
        .count_clr (count_clr),
        .switch_db (switch_db),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((count_en & count_clr) !== 1'b0) begin
                n_fail++;
                $display("FAIL overlap en=%b clr=%b exp no overlap", count_en, count_clr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({state, count_en, count_clr, switch_db} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async got=%b exp=00000", {state, count_en, count_clr, switch_db});
        end
        step();
        step();
        n_checks++;
        if ({state, count_en, count_clr, switch_db} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_held got=%b exp=00000", {state, count_en, count_clr, switch_db});
        end
        rst = 1'b0;
    endtask

    task automatic test_switch_start();
        sw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if (switch_db !== (k == 5) || state !== 2'd0) begin
                n_fail++;
                $display("FAIL start_db k=%0d got db=%b st=%0d exp db=%b st=0",
                         k, switch_db, state, (k == 5));
            end
        end
        for (c = 1; c <= 12; c++) begin
            step();
            n_checks++;
            if (state !== 2'd1 || count_en !== (c % 4 == 0) || count_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL start_run c=%0d got st=%0d en=%b clr=%b exp st=1 en=%b clr=0",
                         c, state, count_en, count_clr, (c % 4 == 0));
            end
        end
        c = 12;
    endtask

    task automatic test_glitch();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            c++;
            if (i == 2) btn = 1'b0;
            n_checks++;
            if (state !== 2'd1 || count_clr !== 1'b0 || count_en !== (c % 4 == 0)) begin
                n_fail++;
                $display("FAIL glitch i=%0d got st=%0d en=%b clr=%b exp st=1 en=%b clr=0",
                         i, state, count_en, count_clr, (c % 4 == 0));
            end
        end
    endtask

    task automatic test_clear_running();
        btn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            c++;
            n_checks++;
            if (state !== 2'd1 || count_en !== (c % 4 == 0)) begin
                n_fail++;
                $display("FAIL clr_pre k=%0d got st=%0d en=%b exp st=1 en=%b",
                         k, state, count_en, (c % 4 == 0));
            end
        end
        step();
        n_checks++;
        if (state !== 2'd3 || count_clr !== 1'b1 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_pulse got st=%0d clr=%b en=%b exp st=3 clr=1 en=0",
                     state, count_clr, count_en);
        end
        for (c = 1; c <= 16; c++) begin
            step();
            if (c == 8) btn = 1'b0;
            n_checks++;
            if (state !== 2'd1 || count_clr !== 1'b0 || count_en !== (c % 4 == 0)) begin
                n_fail++;
                $display("FAIL clr_post c=%0d got st=%0d en=%b clr=%b exp st=1 en=%b clr=0",
                         c, state, count_en, count_clr, (c % 4 == 0));
            end
        end
        c = 16;
    endtask

    task automatic test_pause();
        step();
        c++;
        sw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            c++;
            n_checks++;
            if (state !== 2'd1 || count_en !== (c % 4 == 0) || switch_db !== (k < 5)) begin
                n_fail++;
                $display("FAIL pause_pre k=%0d got st=%0d en=%b db=%b exp st=1 en=%b db=%b",
                         k, state, count_en, switch_db, (c % 4 == 0), (k < 5));
            end
        end
        step();
        sw = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            n_checks++;
            if (state !== 2'd2 || count_en !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold k=%0d got st=%0d en=%b exp st=2 en=0",
                         k, state, count_en);
            end
        end
        for (int r = 1; r <= 3; r++) begin
            step();
            n_checks++;
            if (state !== 2'd1 || count_en !== (r == 2)) begin
                n_fail++;
                $display("FAIL pause_resume r=%0d got st=%0d en=%b exp st=1 en=%b",
                         r, state, count_en, (r == 2));
            end
        end
        c = 5;
    endtask

    task automatic test_coincidence();
        step();
        c++;
        step();
        c++;
        btn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            c++;
            n_checks++;
            if (state !== 2'd1 || count_en !== (c % 4 == 0) || count_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL coin_pre k=%0d got st=%0d en=%b clr=%b exp st=1 en=%b clr=0",
                         k, state, count_en, count_clr, (c % 4 == 0));
            end
        end
        step();
        n_checks++;
        if (state !== 2'd3 || count_clr !== 1'b1 || count_en !== 1'b0) begin
            n_fail++;
            $display("FAIL coin_clear got st=%0d clr=%b en=%b exp st=3 clr=1 en=0",
                     state, count_clr, count_en);
        end
        btn = 1'b0;
        for (c = 1; c <= 11; c++) begin
            step();
            n_checks++;
            if (state !== 2'd1 || count_clr !== 1'b0 || count_en !== (c % 4 == 0)) begin
                n_fail++;
                $display("FAIL coin_post c=%0d got st=%0d en=%b clr=%b exp st=1 en=%b clr=0",
                         c, state, count_en, count_clr, (c % 4 == 0));
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        n_checks++;
        if (count_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_en got=%b exp=1", count_en);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (state !== 2'd0 || count_en !== 1'b0 || count_clr !== 1'b0 || switch_db !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async got st=%0d en=%b clr=%b db=%b exp 0 0 0 0",
                     state, count_en, count_clr, switch_db);
        end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++;
            if (state !== 2'd0 || count_en !== 1'b0 || count_clr !== 1'b0
                || switch_db !== (k == 5)) begin
                n_fail++;
                $display("FAIL rst_redb k=%0d got st=%0d en=%b clr=%b db=%b exp 0 0 0 %b",
                         k, state, count_en, count_clr, switch_db, (k == 5));
            end
        end
        for (int r = 1; r <= 8; r++) begin
            step();
            n_checks++;
            if (state !== 2'd1 || count_en !== (r % 4 == 0) || count_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_run r=%0d got st=%0d en=%b clr=%b exp st=1 en=%b clr=0",
                         r, state, count_en, count_clr, (r % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_switch_start();
        test_glitch();
        test_clear_running();
        test_pause();
        test_coincidence();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
